// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port indices double as bit positions in the per-port ack/err vectors.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin select: a lone requester always wins,
// and a tie goes to the port that was not granted last.
module rr_pick2
    import arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end else if (req1) begin
            grant_idx = PORT_AUX;
        end else begin
            grant_idx = PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU (port 0) and an auxiliary master
// (port 1) with round-robin arbitration and a watchdog on hung transactions.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    // Counter only needs to reach TIMEOUT-1; it wraps harmlessly when the
    // watchdog is disabled.
    localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit            WD_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    arb_state_t    r_state;
    logic          r_last_grant;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_ack;
    logic [1:0]    r_err;

    arb_state_t    w_state_nxt;
    logic          w_last_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_mem_req_nxt;
    logic          w_mem_we_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] w_mem_wdata_nxt;
    logic [DW-1:0] w_rdata_nxt;
    logic [1:0]    w_ack_nxt;
    logic [1:0]    w_err_nxt;
    logic          w_grant_valid;
    logic          w_grant_idx;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // r_last_grant doubles as the owner of the transaction in flight.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        w_state_nxt     = r_state;
        w_last_nxt      = r_last_grant;
        w_cnt_nxt       = r_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        w_ack_nxt       = 2'b00;
        w_err_nxt       = 2'b00;

        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt   = BUSY;
                    w_last_nxt    = w_grant_idx;
                    w_cnt_nxt     = '0;
                    w_mem_req_nxt = 1'b1;
                    if (w_grant_idx == PORT_AUX) begin
                        w_mem_we_nxt    = we1;
                        w_mem_addr_nxt  = addr1;
                        w_mem_wdata_nxt = wdata1;
                    end else begin
                        w_mem_we_nxt    = we0;
                        w_mem_addr_nxt  = addr0;
                        w_mem_wdata_nxt = wdata0;
                    end
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt + CW'(1);
                // A completion in the same cycle as the watchdog expiry wins.
                if (mem_ack) begin
                    w_rdata_nxt             = mem_rdata;
                    w_mem_req_nxt           = 1'b0;
                    w_state_nxt             = RESP;
                    w_ack_nxt[r_last_grant] = 1'b1;
                end else if (WD_EN && (r_cnt == TO_LAST)) begin
                    w_rdata_nxt             = '0;
                    w_mem_req_nxt           = 1'b0;
                    w_state_nxt             = RESP;
                    w_ack_nxt[r_last_grant] = 1'b1;
                    w_err_nxt[r_last_grant] = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_AUX;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
            r_ack        <= 2'b00;
            r_err        <= 2'b00;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the same pre-edge values regardless of order.
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_rdata      <= w_rdata_nxt;
            r_ack        <= w_ack_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign ack0      = r_ack[PORT_CPU];
    assign ack1      = r_ack[PORT_AUX];
    assign err0      = r_err[PORT_CPU];
    assign err1      = r_err[PORT_AUX];
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters and a memory responder
// push expected responses, a monitor pops them on every ack pulse.
module tb_mem_port_arbiter;

    localparam int TO    = 8;
    localparam int NEVER = 1000;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          force_lat = 0;
    bit          model_last = 1'b1;
    exp_t        sb[$];
    bit          ack_log[$];
    logic [31:0] mem_model[logic [31:0]];

    logic        snap_req[2];
    logic        snap_we[2];
    logic [31:0] snap_addr[2];
    logic [31:0] snap_wdata[2];

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .err0      (err0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .err1      (err1),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish, expected finish before %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return $urandom_range(1, 3);
        if (r <= 7) return $urandom_range(4, TO - 1);
        if (r == 8) return TO;
        return NEVER;
    endfunction

    // Requester view the DUT arbitrates on at each rising edge.
    always @(posedge clk) begin
        snap_req[0] = req0;  snap_we[0] = we0;  snap_addr[0] = addr0;  snap_wdata[0] = wdata0;
        snap_req[1] = req1;  snap_we[1] = we1;  snap_addr[1] = addr1;  snap_wdata[1] = wdata1;
    end

    // Issue one request on a port and hold it until that port's ack.
    task automatic issue(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int  n;
        bit  got;
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = port ? ack1 : ack0;
        end
        check($sformatf("ack_wait_p%0d", port), 64'(got), 64'd1);
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
        @(negedge clk);
    endtask

    // Memory model: checks each grant against the round-robin rule, picks a
    // latency and pushes the response the owner should eventually see.
    initial begin : responder
        bit          busy;
        int          cyc, lat, exp_cyc;
        logic        own, o_we;
        logic [31:0] o_addr, o_wdata, resp_data;
        logic        g_we;
        logic [31:0] g_addr, g_wdata;
        busy = 1'b0; cyc = 0; lat = 0; exp_cyc = 0; own = 1'b0;
        o_we = 1'b0; o_addr = '0; o_wdata = '0; resp_data = '0;
        g_we = 1'b0; g_addr = '0; g_wdata = '0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            if (!reset) begin
                busy       = 1'b0;
                model_last = 1'b1;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cyc  = 0;
                    check("grant_has_req", 64'(snap_req[0] | snap_req[1]), 64'd1);
                    if (snap_req[0] && snap_req[1]) own = ~model_last;
                    else                            own = snap_req[1];
                    model_last = own;
                    o_we    = snap_we[own];
                    o_addr  = snap_addr[own];
                    o_wdata = snap_wdata[own];
                    check("grant_we",    64'(mem_we),    64'(o_we));
                    check("grant_addr",  64'(mem_addr),  64'(o_addr));
                    check("grant_wdata", 64'(mem_wdata), 64'(o_wdata));
                    g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
                    lat       = (force_lat != 0) ? force_lat : pick_lat();
                    exp_cyc   = (lat <= TO) ? lat : TO;
                    resp_data = o_we ? $urandom() : mem_rd(o_addr);
                    if (lat <= TO) sb.push_back('{port: own, err: 1'b0, rdata: resp_data});
                    else           sb.push_back('{port: own, err: 1'b1, rdata: 32'h0});
                end else begin
                    check("hold_we",    64'(mem_we),    64'(g_we));
                    check("hold_addr",  64'(mem_addr),  64'(g_addr));
                    check("hold_wdata", 64'(mem_wdata), 64'(g_wdata));
                end
                cyc++;
                if (cyc == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = resp_data;
                    if (o_we) mem_model[o_addr] = o_wdata;
                end
            end else if (busy) begin
                busy = 1'b0;
                check("mem_req_cycles", 64'(cyc), 64'(exp_cyc));
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (ack0 || ack1 || err0 || err1)) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 64'({err1, err0, ack1, ack0}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_vec", 64'({ack1, ack0}), e.port ? 64'd2 : 64'd1);
                    check("err_vec", 64'({err1, err0}), !e.err ? 64'd0 : (e.port ? 64'd2 : 64'd1));
                    check("rdata",   64'(rdata),        64'(e.rdata));
                    ack_log.push_back(ack1);
                end
            end
        end
    end

    initial begin : main
        int n0;
        repeat (3) @(negedge clk);
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata",     64'(rdata),     64'd0);
        check("rst_acks",      64'({err1, err0, ack1, ack0}), 64'd0);
        #2 reset = 1'b1;
        @(negedge clk);

        // Directed: read, write pass-through, timeout, ack/timeout collision.
        mem_model[32'h40] = 32'hDEAD_BEEF;
        force_lat = 2;   issue(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        force_lat = 3;   issue(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678);
        force_lat = NEVER; issue(1'b0, 1'b0, 32'h0000_0080, 32'h0);
        force_lat = TO;  issue(1'b0, 1'b0, 32'h0000_0084, 32'h0);

        // Async reset in the middle of a transaction.
        force_lat = NEVER;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'hC0; wdata0 = 32'h0;
        repeat (4) @(negedge clk);
        check("busy_before_reset", 64'(mem_req), 64'd1);
        #2 reset = 1'b0;
        sb.delete();
        #1 check("reset_drops_mem_req", 64'(mem_req), 64'd0);
        check("reset_no_ack", 64'({ack1, ack0}), 64'd0);
        req0 = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        force_lat = 2;
        n0 = ack_log.size();
        issue(1'b1, 1'b0, 32'h104, 32'h0);
        check("post_reset_lone_p1", 64'(ack_log.size() > n0 && ack_log[n0]), 64'd1);
        n0 = ack_log.size();
        fork
            issue(1'b0, 1'b0, 32'h44, 32'h0);
            issue(1'b1, 1'b0, 32'h108, 32'h0);
        join
        check("double_first_p0", 64'(ack_log.size() == n0 + 2 && ack_log[n0] == 1'b0), 64'd1);

        // Fairness: both ports requesting continuously from reset.
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        force_lat = 1;
        n0 = ack_log.size();
        fork
            begin for (int i = 0; i < 2; i++) issue(1'b0, 1'b0, 32'h48 + 32'(i * 4), 32'h0); end
            begin for (int j = 0; j < 2; j++) issue(1'b1, 1'b1, 32'h10C + 32'(j * 4), $urandom()); end
        join
        check("fair_count", 64'(ack_log.size() - n0), 64'd4);
        for (int k = 0; k < 4 && n0 + k < ack_log.size(); k++)
            check($sformatf("fair_order_%0d", k), 64'(ack_log[n0 + k]), 64'(k % 2));

        // Randomised traffic on both ports with random memory latency.
        force_lat = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom());
                end
            end
            begin
                for (int j = 0; j < 150; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue(1'b1, 1'($urandom_range(0, 1)), 32'h100 + (32'($urandom_range(0, 15)) << 2), $urandom());
                end
            end
        join

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port (Adr/WriteData/ReadData/MemWrite style) between two requesters: port 0 is the multi-cycle CPU core, port 1 is a loader/DMA/debug master.
- Round-robin two-way arbiter with a registered req/ack handshake on each side and a watchdog that aborts hung memory transactions.
- Sits between the core top level and the memory model or memory controller.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, maximum cycles waiting for mem_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0  in  1  port 0 (CPU) request; held until ack0.
- we0  in  1  port 0 write enable.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- ack0  out  1  port 0 completion, one-cycle pulse.
- err0  out  1  port 0 timeout flag, valid with ack0.
- req1, we1, addr1, wdata1, ack1, err1: same as port 0, for port 1.
- rdata  out  DW  registered read data, valid in the ack cycle of the owning port.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one-cycle pulse.

Behaviour:
- Reset values:
  - State IDLE; last_grant = 1, so port 0 wins first.
  - All ack/err outputs 0; mem_req 0; mem_we 0.
  - mem_addr, mem_wdata, rdata all 0.
  - Watchdog counter 0.
  - Reset is async: mem_req drops immediately, even mid-transaction.
- All outputs are registered.
- Requester rules:
  - A requester holds req/we/addr/wdata stable from req rise until the cycle it sees ack.
  - It deasserts req on the next edge.
- State IDLE:
  - If neither req is set, stay in IDLE.
  - If exactly one req is set, grant it.
  - If both are set, grant the port != last_grant.
  - On grant: latch the owner's we/addr/wdata into the mem_* registers, set mem_req=1, set last_grant = owner, clear the counter, go to BUSY.
- State BUSY:
  - mem_req stays 1 and the mem_* outputs hold constant.
  - The counter increments each cycle.
  - On mem_ack: capture rdata = mem_rdata (capture even for writes), drop mem_req, go to RESP with err=0.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no mem_ack: drop mem_req, rdata = 0, go to RESP with err=1.
  - If mem_ack arrives in the same cycle as the timeout, mem_ack wins (err=0).
- State RESP:
  - ack (and err, if set) of the owner is 1 for exactly this cycle; next state is IDLE.
  - The non-owner's ack/err stay 0.
- Latency:
  - req seen in IDLE at edge N → mem_req high after edge N.
  - mem_ack sampled at edge M → ack high after edge M, for one cycle.
  - Minimum turnaround is 3 cycles per transaction.
  - No back-to-back grants: the IDLE cycle after RESP guarantees the finished requester's req is already low.
- Boundary cases:
  - mem_ack while in IDLE or RESP: ignored.
  - A requester withdrawing req while BUSY is a protocol violation; the transaction still completes and acks.
  - A request arriving during BUSY/RESP waits; it is arbitrated in the next IDLE.
  - Continuous requests from both ports alternate strictly: 0,1,0,1…
  - A single continuous requester is served back-to-back with the 1-cycle IDLE gap.
  - Reset mid-BUSY: no ack is issued; the pending transaction is lost.

Decomposition:
- Shared package arb_pkg:
  - arb_state_t enum {IDLE, BUSY, RESP}.
  - Constants PORT_CPU=0 and PORT_AUX=1.
- One sub-module, rr_pick2: combinational two-way round-robin select.
  - Inputs req0, req1, last_grant.
  - Outputs grant_valid, grant_idx.
- Watchdog counter and FSM stay in the top module.

Test Plan:
- Single read: req0=1, addr0=0x0000_0040, mem_ack two cycles after mem_req with mem_rdata=0xDEAD_BEEF → mem_addr=0x40, mem_we=0; ack0 pulses once with rdata=0xDEAD_BEEF, err0=0; ack1 stays 0.
- Write pass-through: req1=1, we1=1, addr1=0x100, wdata1=0x1234_5678 → mem_we=1, mem_addr=0x100, mem_wdata=0x1234_5678 held until mem_ack; ack1 pulses once.
- Fairness: req0 and req1 held continuously from reset, mem_ack after 1 cycle each → grant order 0,1,0,1 over 4 transactions; each transaction is 3+ cycles with an IDLE gap.
- Timeout: TIMEOUT=8, req0=1, mem_ack never asserted → mem_req high exactly 8 cycles, then ack0=1, err0=1, rdata=0, and the FSM returns to IDLE.
- Ack/timeout collision: TIMEOUT=4, mem_ack in the 4th BUSY cycle → err0=0, rdata = mem_rdata.
- Async reset mid-BUSY: reset=0 asserted between edges → mem_req=0 immediately with no ack; after release, req1 pending alone → port 1 granted, and a later double request goes to port 0 first.
